// File: rtl/header_nonce_feeder_if.sv
// Job-configuration and header-stream bus of the nonce feeder.
// The feeder is the slave; the job source / header sink side is the master.
interface header_nonce_feeder_if;
    localparam int unsigned PREFIX_W = 608;
    localparam int unsigned NONCE_W  = 32;
    localparam int unsigned HDR_W    = 640;
    localparam int unsigned CNT_W    = 33;

    logic                cfg_valid;
    logic                cfg_ready;
    logic [PREFIX_W-1:0] cfg_prefix;
    logic [NONCE_W-1:0]  cfg_nonce_start;
    logic [NONCE_W-1:0]  cfg_nonce_end;
    logic                abort;
    logic                hdr_valid;
    logic                hdr_ready;
    logic [HDR_W-1:0]    hdr_data;
    logic [NONCE_W-1:0]  hdr_nonce;
    logic                hdr_last;
    logic                busy;
    logic                done;
    logic                aborted;
    logic [CNT_W-1:0]    issued_count;

    modport master (
        output cfg_valid, cfg_prefix, cfg_nonce_start, cfg_nonce_end, abort, hdr_ready,
        input  cfg_ready, hdr_valid, hdr_data, hdr_nonce, hdr_last, busy, done, aborted,
               issued_count
    );

    modport slave (
        input  cfg_valid, cfg_prefix, cfg_nonce_start, cfg_nonce_end, abort, hdr_ready,
        output cfg_ready, hdr_valid, hdr_data, hdr_nonce, hdr_last, busy, done, aborted,
               issued_count
    );
endinterface

// File: rtl/header_nonce_feeder.sv
// Streams 640-bit block headers {prefix, nonce} over a nonce range, one per accepted
// transfer, ahead of the double-SHA256 hash block.
module header_nonce_feeder #(
    parameter int unsigned STEP            = 1,
    parameter bit          NONCE_BYTE_SWAP = 1'b1
) (
    input logic                  clk,
    input logic                  rst_n,
    header_nonce_feeder_if.slave bus
);
    localparam int unsigned PREFIX_W = 608;
    localparam int unsigned NONCE_W  = 32;
    localparam int unsigned HDR_W    = 640;
    localparam int unsigned CNT_W    = 33;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [PREFIX_W-1:0] prefix_q, prefix_d;
    logic [NONCE_W-1:0]  end_q, end_d;
    logic [NONCE_W-1:0]  nonce_q, nonce_d;
    logic [HDR_W-1:0]    data_q, data_d;
    logic                hdr_valid_q, hdr_valid_d;
    logic                hdr_last_q, hdr_last_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                xfer_c;

    function automatic logic [NONCE_W-1:0] place(input logic [NONCE_W-1:0] n);
        if (NONCE_BYTE_SWAP) return {n[7:0], n[15:8], n[23:16], n[31:24]};
        return n;
    endfunction

    // Final header of the job: fewer than STEP nonces remain up to the inclusive end.
    function automatic logic is_last(input logic [NONCE_W-1:0] e, input logic [NONCE_W-1:0] c);
        logic [NONCE_W-1:0] rem;
        rem = e - c;
        return rem < NONCE_W'(STEP);
    endfunction

    assign xfer_c = hdr_valid_q & bus.hdr_ready;

    always_comb begin
        state_d     = state_q;
        prefix_d    = prefix_q;
        end_d       = end_q;
        nonce_d     = nonce_q;
        data_d      = data_q;
        hdr_valid_d = hdr_valid_q;
        hdr_last_d  = hdr_last_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        count_d     = count_q;

        if (state_q == IDLE) begin
            if (bus.cfg_valid) begin
                state_d     = RUN;
                prefix_d    = bus.cfg_prefix;
                end_d       = bus.cfg_nonce_end;
                nonce_d     = bus.cfg_nonce_start;
                data_d      = {bus.cfg_prefix, place(bus.cfg_nonce_start)};
                hdr_valid_d = 1'b1;
                hdr_last_d  = is_last(bus.cfg_nonce_end, bus.cfg_nonce_start);
                count_d     = '0;
            end
        end else begin
            if (xfer_c) count_d = count_q + CNT_W'(1);
            // A final-header transfer completes normally even if abort is raised with it.
            if ((xfer_c && hdr_last_q) || bus.abort) begin
                state_d     = IDLE;
                hdr_valid_d = 1'b0;
                hdr_last_d  = 1'b0;
                done_d      = 1'b1;
                aborted_d   = !(xfer_c && hdr_last_q);
            end else if (xfer_c) begin
                nonce_d    = nonce_q + NONCE_W'(STEP);
                data_d     = {prefix_q, place(nonce_d)};
                hdr_last_d = is_last(end_q, nonce_d);
            end
        end

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prefix_q    <= '0;
            end_q       <= '0;
            nonce_q     <= '0;
            data_q      <= '0;
            hdr_valid_q <= 1'b0;
            hdr_last_q  <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            busy_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            prefix_q    <= prefix_d;
            end_q       <= end_d;
            nonce_q     <= nonce_d;
            data_q      <= data_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_last_q  <= hdr_last_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            busy_q      <= busy_d;
            count_q     <= count_d;
        end
    end

    assign bus.cfg_ready    = (state_q == IDLE);
    assign bus.hdr_valid    = hdr_valid_q;
    assign bus.hdr_data     = data_q;
    assign bus.hdr_nonce    = nonce_q;
    assign bus.hdr_last     = hdr_last_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.aborted      = aborted_q;
    assign bus.issued_count = count_q;
endmodule

// File: doc/header_nonce_feeder.md
Name: header_nonce_feeder

Overview:
Upstream stage of the double-SHA256 hash block. It accepts a 608-bit header prefix (version, previous-block hash, merkle root, time, bits) and a nonce range. It then streams complete 640-bit headers, one nonce per accepted transfer, over a valid/ready interface. The hdr_data bit layout matches the hash block's 640-bit header input, with the nonce in the least-significant 32 bits.

Parameters:
STEP, 1, nonce increment between consecutive headers; legal range 1..65535.
NONCE_BYTE_SWAP, 1, 1 = nonce bytes reversed (Bitcoin little-endian) when placed in hdr_data[31:0]; 0 = nonce placed as-is.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset
cfg_valid  in  1  job offered
cfg_ready  out  1  block can accept a job (high only in IDLE)
cfg_prefix  in  608  header bits 639:32
cfg_nonce_start  in  32  first nonce
cfg_nonce_end  in  32  inclusive final nonce; range is taken modulo 2^32
abort  in  1  stop current job
hdr_valid  out  1  hdr_data holds a header
hdr_ready  in  1  downstream accepts header
hdr_data  out  640  {prefix, placed nonce}
hdr_nonce  out  32  raw (unswapped) nonce of hdr_data
hdr_last  out  1  current header is the final one of the job
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when a job ends
aborted  out  1  valid with done: 1 = job ended by abort
issued_count  out  33  headers transferred in the current/last job

Behaviour:
- Reset: sampled only on a rising clk edge with rst_n low.
  - State -> IDLE.
  - hdr_valid, hdr_last, done, aborted, busy = 0.
  - hdr_data, hdr_nonce, issued_count = 0.
  - cfg_ready = 1 (a combinational decode of IDLE).
  - Reset mid-job discards the job with no done pulse.
- States: IDLE, RUN.
- IDLE:
  - cfg_ready = 1.
  - On cfg_valid & cfg_ready: latch prefix, start and end; set cur = start; clear issued_count; move to RUN.
  - hdr_valid rises the next cycle, i.e. 1-cycle latency from config accept to the first header.
- RUN:
  - hdr_valid = 1.
  - hdr_data = {prefix, NONCE_BYTE_SWAP ? bswap(cur) : cur}.
  - hdr_nonce = cur.
  - hdr_last = (rem < STEP), where rem = (end - cur) mod 2^32.
- Transfer: occurs on hdr_valid & hdr_ready. On each transfer, issued_count increments.
  - If hdr_last: next cycle done = 1, aborted = 0, state -> IDLE, hdr_valid = 0.
  - Otherwise: cur = cur + STEP (mod 2^32), and the next header is presented the following cycle.
  - Sustained throughput is one header per cycle while hdr_ready is held high.
- Stability: while hdr_valid = 1 and no transfer occurs, hdr_data, hdr_nonce and hdr_last hold. abort is the sole exception.
- Range rules:
  - end < start wraps through 0xFFFFFFFF to 0.
  - start == end yields exactly one header.
  - start = 0, end = 0xFFFFFFFF, STEP = 1 yields 2^32 headers; issued_count reads 0x1_0000_0000 at done.
  - With STEP > 1, the final nonce is the last cur satisfying rem < STEP; it need not equal end.
- Abort in RUN:
  - A transfer in the same cycle completes and is counted.
  - Next cycle: state -> IDLE, hdr_valid = 0, done = 1, aborted = 1.
  - If abort coincides with a hdr_last transfer, the job reports aborted = 0 (normal completion wins).
  - Abort in IDLE is ignored.
- Config ignoring: cfg_valid in RUN is not accepted (cfg_ready = 0).
  - Upstream holds cfg_valid with stable data until acceptance.
- Back-to-back jobs: a job can be accepted in the cycle done pulses (state already IDLE), giving a 1-cycle hdr_valid gap between jobs.
- issued_count holds its final value in IDLE until the next job is accepted.

Test Plan:
1. Reset then prefix = 608'h1…, start = 0x10, end = 0x13, STEP = 1, hdr_ready = 1 -> 4 consecutive hdr_valid cycles starting 1 cycle after accept; hdr_nonce 0x10..0x13; hdr_data[31:0] = 0x10000000..0x13000000 (swap = 1); hdr_last only on 0x13; done pulse next cycle; issued_count = 4.
2. start = 0xFFFFFFFE, end = 0x00000001 -> nonces FFFFFFFE, FFFFFFFF, 0, 1; hdr_last on 1; issued_count = 4.
3. hdr_ready toggled randomly (50%) with start = 5, end = 9 -> hdr_data stable while stalled; no nonce skipped or duplicated; 5 transfers total.
4. STEP = 4, start = 0, end = 10 -> nonces 0, 4, 8; hdr_last on 8; issued_count = 3.
5. Abort asserted with hdr_ready = 1 on the nonce-2 transfer of a 0..100 job -> transfers 0, 1, 2 counted (issued_count = 3); done = 1, aborted = 1; cfg_ready = 1 the same cycle. A second abort pulse on the last header of a fresh job gives aborted = 0.
6. rst_n driven low mid-RUN for one edge -> next cycle hdr_valid = 0, issued_count = 0, no done pulse, cfg_ready = 1; start = end = 7 then yields a single header with hdr_last = 1.
